// File: rtl/beep_sched.sv
// Note scheduler/arbiter for the PWM beeper: grants one of three note sources by fixed
// priority, drives the tone period for the note length, then a silent gap (50 MHz nominal clock).
module beep_sched #(
   parameter int unsigned TICK_DIV = 6_250_000,
   parameter int unsigned GAP_CYC  = 500_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  req,
   input  logic [59:0] note_cycle_i,
   input  logic [23:0] note_len_i,
   input  logic        pause,
   output logic [2:0]  gnt,
   output logic [2:0]  done,
   output logic [2:0]  abrt,
   output logic [19:0] cycle_o,
   output logic        tone_en,
   output logic        busy,
   output logic [1:0]  owner
);

   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

   localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
   localparam logic [31:0] GAP_LAST  = 32'(GAP_CYC - 1);

   state_t      state_reg;
   logic [19:0] per_reg;
   logic [7:0]  len_reg;
   logic [31:0] cyc_cnt_reg;
   logic [7:0]  tick_cnt_reg;
   logic [31:0] gap_cnt_reg;
   logic [1:0]  owner_reg;
   logic [2:0]  gnt_reg;
   logic [2:0]  done_reg;
   logic [2:0]  abrt_reg;
   logic [19:0] cycle_reg;
   logic        tone_en_reg;
   logic        busy_reg;

   logic [19:0] src_cycle [4];
   logic [7:0]  src_len   [4];
   logic [2:0]  hi_mask;
   logic [1:0]  win_idx;
   logic [19:0] win_cycle;
   logic [7:0]  win_len;
   logic        preempt;
   logic        play_last;
   logic        gap_last;
   logic [2:0]  owner_hot;

   // Index 3 is a dummy slot so the 2-bit owner/winner index never reads out of range.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_src
         if (gi < 3) begin : g_real
            assign src_cycle[gi] = note_cycle_i[gi*20 +: 20];
            assign src_len[gi]   = note_len_i[gi*8 +: 8];
         end else begin : g_dummy
            assign src_cycle[gi] = 20'd0;
            assign src_len[gi]   = 8'd0;
         end
      end
      for (gi = 0; gi < 3; gi++) begin : g_hi
         assign hi_mask[gi] = (2'(gi) < owner_reg);
      end
   endgenerate

   always_comb begin
      win_idx = 2'd2;
      if (req[1]) win_idx = 2'd1;
      if (req[0]) win_idx = 2'd0;
   end

   assign win_cycle = src_cycle[win_idx];
   assign win_len   = src_len[win_idx];
   assign preempt   = |(req & hi_mask);
   assign play_last = (tick_cnt_reg == len_reg - 8'd1) && (cyc_cnt_reg == TICK_LAST);
   assign gap_last  = (gap_cnt_reg == GAP_LAST);
   assign owner_hot = 3'b001 << owner_reg;

   // Completion is tested before preemption so a coinciding req never steals a finished note.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         per_reg      <= 20'd0;
         len_reg      <= 8'd0;
         cyc_cnt_reg  <= 32'd0;
         tick_cnt_reg <= 8'd0;
         gap_cnt_reg  <= 32'd0;
         owner_reg    <= 2'd3;
         gnt_reg      <= 3'd0;
         done_reg     <= 3'd0;
         abrt_reg     <= 3'd0;
         cycle_reg    <= 20'd0;
         tone_en_reg  <= 1'b0;
         busy_reg     <= 1'b0;
      end else begin
         gnt_reg  <= 3'd0;
         done_reg <= 3'd0;
         abrt_reg <= 3'd0;
         case (state_reg)
            IDLE: begin
               if (!pause && (req != 3'd0)) begin
                  gnt_reg      <= 3'b001 << win_idx;
                  per_reg      <= win_cycle;
                  len_reg      <= win_len;
                  owner_reg    <= win_idx;
                  busy_reg     <= 1'b1;
                  cyc_cnt_reg  <= 32'd0;
                  tick_cnt_reg <= 8'd0;
                  gap_cnt_reg  <= 32'd0;
                  if (win_len != 8'd0) begin
                     state_reg   <= PLAY;
                     tone_en_reg <= (win_cycle != 20'd0);
                     cycle_reg   <= win_cycle;
                  end else begin
                     state_reg   <= GAP;
                     tone_en_reg <= 1'b0;
                     cycle_reg   <= 20'd0;
                  end
               end
            end
            PLAY: begin
               if (pause) begin
                  tone_en_reg <= 1'b0;
                  cycle_reg   <= 20'd0;
               end else if (play_last) begin
                  state_reg    <= GAP;
                  tone_en_reg  <= 1'b0;
                  cycle_reg    <= 20'd0;
                  cyc_cnt_reg  <= 32'd0;
                  tick_cnt_reg <= 8'd0;
                  gap_cnt_reg  <= 32'd0;
               end else if (preempt) begin
                  state_reg    <= IDLE;
                  abrt_reg     <= owner_hot;
                  owner_reg    <= 2'd3;
                  busy_reg     <= 1'b0;
                  tone_en_reg  <= 1'b0;
                  cycle_reg    <= 20'd0;
                  cyc_cnt_reg  <= 32'd0;
                  tick_cnt_reg <= 8'd0;
               end else begin
                  tone_en_reg <= (per_reg != 20'd0);
                  cycle_reg   <= per_reg;
                  if (cyc_cnt_reg == TICK_LAST) begin
                     cyc_cnt_reg  <= 32'd0;
                     tick_cnt_reg <= tick_cnt_reg + 8'd1;
                  end else begin
                     cyc_cnt_reg <= cyc_cnt_reg + 32'd1;
                  end
               end
            end
            GAP: begin
               tone_en_reg <= 1'b0;
               cycle_reg   <= 20'd0;
               if (pause) begin
                  gap_cnt_reg <= gap_cnt_reg;
               end else if (gap_last) begin
                  state_reg   <= IDLE;
                  done_reg    <= owner_hot;
                  owner_reg   <= 2'd3;
                  busy_reg    <= 1'b0;
                  gap_cnt_reg <= 32'd0;
               end else if (preempt) begin
                  state_reg   <= IDLE;
                  abrt_reg    <= owner_hot;
                  owner_reg   <= 2'd3;
                  busy_reg    <= 1'b0;
                  gap_cnt_reg <= 32'd0;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg + 32'd1;
               end
            end
            default: begin
               state_reg   <= IDLE;
               owner_reg   <= 2'd3;
               busy_reg    <= 1'b0;
               tone_en_reg <= 1'b0;
               cycle_reg   <= 20'd0;
            end
         endcase
      end
   end

   assign gnt     = gnt_reg;
   assign done    = done_reg;
   assign abrt    = abrt_reg;
   assign cycle_o = cycle_reg;
   assign tone_en = tone_en_reg;
   assign busy    = busy_reg;
   assign owner   = owner_reg;

endmodule

// File: tb/tb_beep_sched.sv
// Directed bench for beep_sched with TICK_DIV = 4 and GAP_CYC = 3.
module tb_beep_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  req;
   logic [59:0] note_cycle_i;
   logic [23:0] note_len_i;
   logic        pause;
   logic [2:0]  gnt;
   logic [2:0]  done;
   logic [2:0]  abrt;
   logic [19:0] cycle_o;
   logic        tone_en;
   logic        busy;
   logic [1:0]  owner;

   int total = 0;
   int bad   = 0;

   beep_sched #(.TICK_DIV(4), .GAP_CYC(3)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .note_cycle_i(note_cycle_i),
      .note_len_i(note_len_i), .pause(pause), .gnt(gnt), .done(done), .abrt(abrt),
      .cycle_o(cycle_o), .tone_en(tone_en), .busy(busy), .owner(owner)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int src, input logic [19:0] per, input logic [7:0] len);
      note_cycle_i[src*20 +: 20] = per;
      note_len_i[src*8 +: 8]     = len;
   endtask

   // Called in the grant cycle; walks the whole note and ends in the done cycle.
   task automatic expect_note(input int src, input logic [19:0] per, input int len);
      chk("gnt", 32'(gnt), 32'(1) << src);
      chk("owner", 32'(owner), 32'(src));
      chk("busy", 32'(busy), 32'd1);
      for (int i = 0; i < len * 4; i++) begin
         if (i > 0) step();
         chk("play_tone_en", 32'(tone_en), 32'(per != 20'd0));
         chk("play_cycle_o", 32'(cycle_o), 32'(per));
         chk("play_done", 32'(done), 32'd0);
      end
      for (int i = 0; i < 3; i++) begin
         if (i > 0 || len != 0) step();
         chk("gap_tone_en", 32'(tone_en), 32'd0);
         chk("gap_cycle_o", 32'(cycle_o), 32'd0);
         chk("gap_busy", 32'(busy), 32'd1);
         chk("gap_done", 32'(done), 32'd0);
      end
      step();
      chk("done", 32'(done), 32'(1) << src);
      chk("done_owner", 32'(owner), 32'd3);
      chk("done_busy", 32'(busy), 32'd0);
      $display("note src=%0d per=%0d len=%0d complete", src, per, len);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; req = 3'd0; pause = 1'b0;
      note_cycle_i = 60'd0; note_len_i = 24'd0;
      step(); step();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_abrt", 32'(abrt), 32'd0);
      chk("rst_cycle_o", 32'(cycle_o), 32'd0);
      chk("rst_tone_en", 32'(tone_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_owner", 32'(owner), 32'd3);
      rst_n = 1'b1;
      step();
      $display("reset checked");

      // Single note
      load(1, 20'd1000, 8'd2);
      req = 3'b010;
      step();
      req = 3'b000;
      expect_note(1, 20'd1000, 2);

      // Priority: src1 first, src2 straight after done[1]
      load(1, 20'd111, 8'd1);
      load(2, 20'd222, 8'd1);
      req = 3'b110;
      step();
      req = 3'b100;
      expect_note(1, 20'd111, 1);
      step();
      req = 3'b000;
      expect_note(2, 20'd222, 1);

      // Preemption of src2 by src0 in PLAY cycle 6
      load(2, 20'd300, 8'd5);
      req = 3'b100;
      step();
      req = 3'b000;
      chk("pre_gnt2", 32'(gnt), 32'b100);
      for (int i = 1; i < 6; i++) begin
         step();
         chk("pre_tone", 32'(tone_en), 32'd1);
      end
      load(0, 20'd500, 8'd1);
      req = 3'b001;
      step();
      chk("abrt", 32'(abrt), 32'b100);
      chk("abrt_owner", 32'(owner), 32'd3);
      chk("abrt_tone", 32'(tone_en), 32'd0);
      chk("abrt_busy", 32'(busy), 32'd0);
      chk("abrt_done", 32'(done), 32'd0);
      step();
      req = 3'b000;
      chk("abrt_after", 32'(abrt), 32'd0);
      expect_note(0, 20'd500, 1);
      $display("preemption checked");

      // Zero length and rest
      load(0, 20'd77, 8'd0);
      req = 3'b001;
      step();
      req = 3'b000;
      expect_note(0, 20'd77, 0);
      load(1, 20'd0, 8'd3);
      req = 3'b010;
      step();
      req = 3'b000;
      expect_note(1, 20'd0, 3);

      // Pause mid-PLAY for 5 cycles
      load(1, 20'd700, 8'd2);
      req = 3'b010;
      step();
      req = 3'b000;
      chk("pause_gnt", 32'(gnt), 32'b010);
      step(); step();
      chk("pause_pre_tone", 32'(tone_en), 32'd1);
      pause = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("pause_tone", 32'(tone_en), 32'd0);
         chk("pause_cycle_o", 32'(cycle_o), 32'd0);
         chk("pause_busy", 32'(busy), 32'd1);
      end
      pause = 1'b0;
      step();
      chk("resume_tone", 32'(tone_en), 32'd1);
      chk("resume_cycle_o", 32'(cycle_o), 32'd700);
      n = 8;
      while (done == 3'd0 && n < 40) begin
         step();
         n++;
      end
      chk("pause_done_lat", 32'(n), 32'd16);
      chk("pause_done", 32'(done), 32'b010);
      $display("pause: done %0d cycles after grant", n);

      // Pause in IDLE blocks grants
      pause = 1'b1;
      load(1, 20'd444, 8'd1);
      req = 3'b010;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("idle_pause_gnt", 32'(gnt), 32'd0);
         chk("idle_pause_busy", 32'(busy), 32'd0);
      end
      pause = 1'b0;
      step();
      req = 3'b000;
      expect_note(1, 20'd444, 1);

      // Reset mid-note
      load(1, 20'd900, 8'd3);
      req = 3'b010;
      step();
      req = 3'b000;
      step(); step(); step();
      chk("pre_rst_tone", 32'(tone_en), 32'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("mrst_tone", 32'(tone_en), 32'd0);
      chk("mrst_cycle_o", 32'(cycle_o), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_owner", 32'(owner), 32'd3);
      chk("mrst_done", 32'(done), 32'd0);
      chk("mrst_abrt", 32'(abrt), 32'd0);
      for (int i = 0; i < 15; i++) begin
         step();
         chk("post_rst_done", 32'(done), 32'd0);
         chk("post_rst_abrt", 32'(abrt), 32'd0);
      end
      load(2, 20'd1234, 8'd1);
      req = 3'b100;
      step();
      req = 3'b000;
      expect_note(2, 20'd1234, 1);
      $display("reset mid-note checked");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
